// File: rtl/acqctrl_pkg.sv
// Shared types for the acqbuf capture controller: FSM state encoding and default widths.
package acqctrl_pkg;

    localparam int ACQ_ADDRWIDTH = 9;
    localparam int ACQ_DATAWIDTH = 64;
    localparam int ACQ_DLYWIDTH  = 16;
    localparam int ACQ_DECWIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        CAPTURE,
        DONE
    } acqctrl_state_t;

endpackage

// File: rtl/acqbuf_capture_ctrl.sv
// Arm/trigger/delay/capture sequencer driving one acqbuf BRAM write port.
// Optional ACQBUF_CAPTURE_TSTAMP_EN adds a free-running cycle counter and trig_tstamp output.
module acqbuf_capture_ctrl
    import acqctrl_pkg::*;
#(
    parameter int ADDRWIDTH = ACQ_ADDRWIDTH,
    parameter int DATAWIDTH = ACQ_DATAWIDTH,
    parameter int DLYWIDTH  = ACQ_DLYWIDTH,
    parameter int DECWIDTH  = ACQ_DECWIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stb_arm,
    input  logic                 stb_abort,
    input  logic                 trig,
    input  logic [DLYWIDTH-1:0]  delay,
    input  logic [ADDRWIDTH:0]   length,
    input  logic [DECWIDTH-1:0]  decim,
    input  logic [DATAWIDTH-1:0] din,
    output logic [ADDRWIDTH-1:0] addr_o,
    output logic [DATAWIDTH-1:0] data_o,
    output logic                 we_o,
    output logic                 busy,
    output logic                 done,
`ifdef ACQBUF_CAPTURE_TSTAMP_EN
    output logic [31:0]          trig_tstamp,
`endif
    output logic [ADDRWIDTH:0]   wr_count
);

    localparam logic [ADDRWIDTH:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

    acqctrl_state_t state, next_state;

    logic [DLYWIDTH-1:0]  dly_q, dly_cnt;
    logic [ADDRWIDTH:0]   len_q;
    logic [DECWIDTH-1:0]  dec_q, dec_cnt;
    logic                 arm_ok, accept, sample;

    assign arm_ok = stb_arm && !stb_abort && (state == IDLE || state == DONE);
    assign accept = (state == ARMED) && trig && !stb_abort;
    assign busy   = (state == ARMED) || (state == DELAY) || (state == CAPTURE);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // wr_count doubles as the sample index, so CAPTURE ends once the last write is on the bus.
    always_comb begin
        next_state = state;
        sample     = 1'b0;
        if (stb_abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (stb_arm) next_state = ARMED;
                ARMED: begin
                    if (trig) begin
                        if (dly_q != '0)      next_state = DELAY;
                        else if (len_q == '0) next_state = DONE;
                        else                  next_state = CAPTURE;
                    end
                end
                DELAY: begin
                    if (dly_cnt == '0) next_state = (len_q == '0) ? DONE : CAPTURE;
                end
                CAPTURE: begin
                    if (wr_count == len_q)  next_state = DONE;
                    else if (dec_cnt == '0) sample = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_q    <= '0;
            len_q    <= '0;
            dec_q    <= '0;
            dly_cnt  <= '0;
            dec_cnt  <= '0;
            wr_count <= '0;
            addr_o   <= '0;
            data_o   <= '0;
            we_o     <= 1'b0;
        end else begin
            we_o <= sample;
            if (arm_ok) begin
                dly_q    <= delay;
                len_q    <= (length > DEPTH) ? DEPTH : length;
                dec_q    <= decim;
                dec_cnt  <= '0;
                wr_count <= '0;
                addr_o   <= '0;
            end
            // Loaded one short: the trigger cycle itself is not part of the delay.
            if (accept) dly_cnt <= dly_q - 1'b1;
            else if (state == DELAY && dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
            if (sample) begin
                dec_cnt  <= dec_q;
                addr_o   <= wr_count[ADDRWIDTH-1:0];
                data_o   <= din;
                wr_count <= wr_count + 1'b1;
            end else if (state == CAPTURE && dec_cnt != '0) begin
                dec_cnt <= dec_cnt - 1'b1;
            end
        end
    end

`ifdef ACQBUF_CAPTURE_TSTAMP_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt     <= '0;
            trig_tstamp <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (accept) trig_tstamp <= cyc_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_acqbuf_capture_ctrl.sv
// Directed bench for acqbuf_capture_ctrl; din carries its own cycle number so writes are traceable.
module tb_acqbuf_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stb_arm = 1'b0, stb_abort = 1'b0, trig = 1'b0;
    logic [15:0] delay = '0;
    logic [9:0]  length = '0;
    logic [7:0]  decim = '0;
    logic [63:0] din = '0;
    logic [8:0]  addr_o;
    logic [63:0] data_o;
    logic        we_o, busy, done;
    logic [9:0]  wr_count;
`ifdef ACQBUF_CAPTURE_TSTAMP_EN
    logic [31:0] trig_tstamp;
`endif

    int pass = 0, chks = 0;
    int cyc = 0;
    int wa[$];
    logic [63:0] wd[$];
    int wc[$];

    acqbuf_capture_ctrl dut (
        .clk(clk), .reset(rst_n), .stb_arm(stb_arm), .stb_abort(stb_abort), .trig(trig),
        .delay(delay), .length(length), .decim(decim), .din(din),
        .addr_o(addr_o), .data_o(data_o), .we_o(we_o), .busy(busy), .done(done),
`ifdef ACQBUF_CAPTURE_TSTAMP_EN
        .trig_tstamp(trig_tstamp),
`endif
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] f(int c);
        return {32'hDA7A0000, c};
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge clk) begin
        din = f(cyc);
        if (rst_n && we_o) begin
            wa.push_back(int'(addr_o));
            wd.push_back(data_o);
            wc.push_back(cyc);
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
    endtask

    task automatic arm(input int d, input int l, input int dc);
        @(negedge clk);
        delay = 16'(d); length = 10'(l); decim = 8'(dc); stb_arm = 1'b1;
        @(negedge clk);
        stb_arm = 1'b0;
        delay = 16'hFFFF; length = 10'd1; decim = 8'd7;
    endtask

    task automatic pulse_trig(output int t);
        @(negedge clk);
        trig = 1'b1; t = cyc;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin dcyc = cyc; return; end
            @(negedge clk);
        end
        chks++;
        $display("FAIL done_timeout: done not seen within %0d cycles", budget);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        chks++; if (we_o !== 1'b0)      $display("FAIL rst_we: got %b exp 0", we_o); else pass++;
        chks++; if (addr_o !== 9'd0)    $display("FAIL rst_addr: got %0d exp 0", addr_o); else pass++;
        chks++; if (data_o !== 64'd0)   $display("FAIL rst_data: got %h exp 0", data_o); else pass++;
        chks++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %b exp 0", busy); else pass++;
        chks++; if (done !== 1'b0)      $display("FAIL rst_done: got %b exp 0", done); else pass++;
        chks++; if (wr_count !== 10'd0) $display("FAIL rst_wrcnt: got %0d exp 0", wr_count); else pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int t, dc;
        clear_log();
        arm(0, 4, 0);
        chks++; if (busy !== 1'b1) $display("FAIL basic_armed_busy: got %b exp 1", busy); else pass++;
        pulse_trig(t);
        wait_done(50, dc);
        chks++; if (dc !== t + 6) $display("FAIL basic_done_cyc: got %0d exp %0d", dc, t + 6); else pass++;
        chks++; if (wa.size() !== 4) $display("FAIL basic_nwr: got %0d exp 4", wa.size()); else pass++;
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            chks++; if (wa[i] !== i) $display("FAIL basic_addr%0d: got %0d exp %0d", i, wa[i], i); else pass++;
            chks++; if (wd[i] !== f(t + 1 + i)) $display("FAIL basic_data%0d: got %h exp %h", i, wd[i], f(t + 1 + i)); else pass++;
            chks++; if (wc[i] !== t + 2 + i) $display("FAIL basic_wecyc%0d: got %0d exp %0d", i, wc[i], t + 2 + i); else pass++;
        end
        chks++; if (wr_count !== 10'd4) $display("FAIL basic_wrcnt: got %0d exp 4", wr_count); else pass++;
        chks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b exp 0", busy); else pass++;
    endtask

    task automatic test_delay_decim();
        int t, dc;
        int offs[3] = '{11, 14, 17};
        clear_log();
        arm(10, 3, 2);
        pulse_trig(t);
        wait_done(100, dc);
        chks++; if (wa.size() !== 3) $display("FAIL dly_nwr: got %0d exp 3", wa.size()); else pass++;
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            chks++; if (wd[i] !== f(t + offs[i])) $display("FAIL dly_data%0d: got %h exp %h", i, wd[i], f(t + offs[i])); else pass++;
            chks++; if (wa[i] !== i) $display("FAIL dly_addr%0d: got %0d exp %0d", i, wa[i], i); else pass++;
        end
        chks++; if (wr_count !== 10'd3) $display("FAIL dly_wrcnt: got %0d exp 3", wr_count); else pass++;
        chks++; if (done !== 1'b1) $display("FAIL dly_done: got %b exp 1", done); else pass++;
    endtask

    task automatic test_length_clamp();
        int t, dc, bad;
        clear_log();
        arm(0, 600, 0);
        pulse_trig(t);
        wait_done(700, dc);
        @(negedge clk);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== i) bad++;
        chks++; if (wa.size() !== 512) $display("FAIL clamp_nwr: got %0d exp 512", wa.size()); else pass++;
        chks++; if (bad !== 0) $display("FAIL clamp_addr_seq: %0d out-of-order addresses exp 0", bad); else pass++;
        chks++; if (wa.size() > 0 && wa[wa.size()-1] !== 511) $display("FAIL clamp_last_addr: got %0d exp 511", wa[wa.size()-1]); else pass++;
        chks++; if (wr_count !== 10'd512) $display("FAIL clamp_wrcnt: got %0d exp 512", wr_count); else pass++;
        chks++; if (done !== 1'b1) $display("FAIL clamp_done: got %b exp 1", done); else pass++;
    endtask

    task automatic test_abort();
        int t, g;
        clear_log();
        arm(0, 20, 0);
        pulse_trig(t);
        for (int i = 0; i < 20 && cyc < t + 6; i++) @(negedge clk);
        stb_abort = 1'b1;
        @(negedge clk);
        stb_abort = 1'b0;
        chks++; if (we_o !== 1'b0) $display("FAIL abort_we: got %b exp 0", we_o); else pass++;
        chks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b exp 0", busy); else pass++;
        chks++; if (wr_count !== 10'd5) $display("FAIL abort_wrcnt: got %0d exp 5", wr_count); else pass++;
        repeat (3) @(negedge clk);
        chks++; if (wa.size() !== 5) $display("FAIL abort_nwr: got %0d exp 5", wa.size()); else pass++;
        // trig while IDLE
        pulse_trig(g);
        repeat (3) @(negedge clk);
        chks++; if (busy !== 1'b0 || wa.size() !== 5) $display("FAIL idle_trig: busy %b nwr %0d exp 0/5", busy, wa.size()); else pass++;
        // arm and abort together
        stb_arm = 1'b1; stb_abort = 1'b1; length = 10'd4;
        @(negedge clk);
        stb_arm = 1'b0; stb_abort = 1'b0;
        chks++; if (busy !== 1'b0) $display("FAIL arm_abort_busy: got %b exp 0", busy); else pass++;
        chks++; if (wr_count !== 10'd5) $display("FAIL arm_abort_wrcnt: got %0d exp 5", wr_count); else pass++;
        // arm and trig together: trigger is not remembered
        delay = 16'd0; length = 10'd4; decim = 8'd0; stb_arm = 1'b1; trig = 1'b1;
        @(negedge clk);
        stb_arm = 1'b0; trig = 1'b0;
        repeat (4) @(negedge clk);
        chks++; if (busy !== 1'b1 || wa.size() !== 5) $display("FAIL arm_trig_same: busy %b nwr %0d exp 1/5", busy, wa.size()); else pass++;
        stb_abort = 1'b1;
        @(negedge clk);
        stb_abort = 1'b0;
    endtask

    task automatic test_ignore();
        int t, dc, g;
        clear_log();
        arm(0, 6, 1);
        pulse_trig(t);
        for (int i = 0; i < 10 && cyc < t + 3; i++) @(negedge clk);
        stb_arm = 1'b1; length = 10'd2; decim = 8'd0;
        @(negedge clk);
        stb_arm = 1'b0; trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        wait_done(50, dc);
        chks++; if (dc !== t + 13) $display("FAIL ign_done_cyc: got %0d exp %0d", dc, t + 13); else pass++;
        chks++; if (wa.size() !== 6) $display("FAIL ign_nwr: got %0d exp 6", wa.size()); else pass++;
        for (int i = 0; i < 6 && i < wa.size(); i++) begin
            chks++; if (wa[i] !== i || wd[i] !== f(t + 1 + 2*i))
                $display("FAIL ign_wr%0d: got addr %0d data %h exp %0d %h", i, wa[i], wd[i], i, f(t + 1 + 2*i)); else pass++;
        end
        // trig while DONE
        pulse_trig(g);
        repeat (2) @(negedge clk);
        chks++; if (done !== 1'b1 || busy !== 1'b0 || wa.size() !== 6)
            $display("FAIL done_trig: done %b busy %b nwr %0d exp 1/0/6", done, busy, wa.size()); else pass++;
        // zero length
        clear_log();
        arm(0, 0, 0);
        chks++; if (done !== 1'b0) $display("FAIL len0_armed_done: got %b exp 0", done); else pass++;
        pulse_trig(t);
        wait_done(20, dc);
        chks++; if (dc !== t + 1) $display("FAIL len0_done_cyc: got %0d exp %0d", dc, t + 1); else pass++;
        repeat (2) @(negedge clk);
        chks++; if (wa.size() !== 0 || wr_count !== 10'd0) $display("FAIL len0_writes: nwr %0d wrcnt %0d exp 0/0", wa.size(), wr_count); else pass++;
    endtask

`ifdef ACQBUF_CAPTURE_TSTAMP_EN
    task automatic test_tstamp();
        int t, dc, g;
        arm(0, 2, 0);
        for (int i = 0; i < 2000 && cyc < 1233; i++) @(negedge clk);
        pulse_trig(t);
        wait_done(20, dc);
        chks++; if (trig_tstamp !== 32'd1234) $display("FAIL tstamp: got %0d exp 1234", trig_tstamp); else pass++;
        pulse_trig(g);
        repeat (3) @(negedge clk);
        chks++; if (trig_tstamp !== 32'd1234) $display("FAIL tstamp_hold: got %0d exp 1234", trig_tstamp); else pass++;
    endtask
`endif

    task automatic test_reset_mid();
        int t, n;
        clear_log();
        arm(0, 100, 0);
        pulse_trig(t);
        repeat (5) @(negedge clk);
        chks++; if (we_o !== 1'b1) $display("FAIL midrst_pre_we: got %b exp 1", we_o); else pass++;
        rst_n = 1'b0;
        #1;
        chks++; if (we_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_ctl: we %b busy %b done %b exp 0/0/0", we_o, busy, done); else pass++;
        chks++; if (addr_o !== 9'd0 || data_o !== 64'd0 || wr_count !== 10'd0)
            $display("FAIL midrst_data: addr %0d data %h wrcnt %0d exp 0", addr_o, data_o, wr_count); else pass++;
`ifdef ACQBUF_CAPTURE_TSTAMP_EN
        chks++; if (trig_tstamp !== 32'd0) $display("FAIL midrst_tstamp: got %0d exp 0", trig_tstamp); else pass++;
`endif
        n = wa.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chks++; if (wa.size() !== n || we_o !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_after: nwr %0d we %b busy %b exp %0d/0/0", wa.size(), we_o, busy, n); else pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay_decim();
        test_length_clamp();
        test_abort();
        test_ignore();
`ifdef ACQBUF_CAPTURE_TSTAMP_EN
        test_tstamp();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chks);
        $finish;
    end

endmodule
